ooo_issue_queue4: RTL

// 4-entry reservation station / issue queue feeding one execution unit.

---
 rtl/ooo_issue_queue4.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ooo_issue_queue4.sv
// Four-entry issue queue for one execution unit: holds dispatched ops until both
// source operands are ready, wakes them from the CDB, and issues the lowest-index ready entry.
module ooo_issue_queue4 #(
  parameter int tag_width_p  = 4,
  parameter int data_width_p = 32,
  parameter int op_width_p   = 8,
  parameter int rob_width_p  = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    flush_i,
  input  logic                    disp_v_i,
  output logic                    disp_ready_o,
  input  logic [op_width_p-1:0]   disp_op_i,
  input  logic [rob_width_p-1:0]  disp_rob_i,
  input  logic                    disp_s1_rdy_i,
  input  logic [tag_width_p-1:0]  disp_s1_tag_i,
  input  logic [data_width_p-1:0] disp_s1_val_i,
  input  logic                    disp_s2_rdy_i,
  input  logic [tag_width_p-1:0]  disp_s2_tag_i,
  input  logic [data_width_p-1:0] disp_s2_val_i,
  input  logic                    cdb_v_i,
  input  logic [tag_width_p-1:0]  cdb_tag_i,
  input  logic [data_width_p-1:0] cdb_val_i,
  output logic                    issue_v_o,
  input  logic                    issue_yumi_i,
  output logic [op_width_p-1:0]   issue_op_o,
  output logic [rob_width_p-1:0]  issue_rob_o,
  output logic [data_width_p-1:0] issue_s1_o,
  output logic [data_width_p-1:0] issue_s2_o,
  output logic [2:0]              count_o
);

  // Lowest-index-wins one-hot priority encoder.
  function automatic logic [3:0] pe_one_hot_lo(input logic [3:0] req);
    logic [3:0] grant;
    grant = 4'b0000;
    if (req[0])      grant = 4'b0001;
    else if (req[1]) grant = 4'b0010;
    else if (req[2]) grant = 4'b0100;
    else if (req[3]) grant = 4'b1000;
    else             grant = 4'b0000;
    return grant;
  endfunction

  logic [3:0]              v_r, s1_rdy_r, s2_rdy_r;
  logic [op_width_p-1:0]   op_r     [4];
  logic [rob_width_p-1:0]  rob_r    [4];
  logic [tag_width_p-1:0]  s1_tag_r [4];
  logic [tag_width_p-1:0]  s2_tag_r [4];
  logic [data_width_p-1:0] s1_val_r [4];
  logic [data_width_p-1:0] s2_val_r [4];
  logic [2:0]              count_r;

  logic [3:0]              ready_vec_s, sel_s, sel_g_s, free_oh_s;
  logic                    disp_fire_s, yumi_fire_s;
  logic                    d_s1_rdy_s, d_s2_rdy_s;
  logic [data_width_p-1:0] d_s1_val_s, d_s2_val_s;

  // Select, free-slot search, handshakes and issue payload mux.
  always_comb begin
    ready_vec_s  = v_r & s1_rdy_r & s2_rdy_r;
    sel_s        = pe_one_hot_lo(ready_vec_s);
    free_oh_s    = pe_one_hot_lo(~v_r);
    issue_v_o    = (|ready_vec_s) & ~flush_i & reset_n_i;
    disp_ready_o = (|(~v_r)) & ~flush_i & reset_n_i;
    disp_fire_s  = disp_v_i & disp_ready_o;
    yumi_fire_s  = issue_yumi_i & issue_v_o;
    if (issue_v_o) sel_g_s = sel_s;
    else           sel_g_s = 4'b0000;
    issue_op_o  = '0;
    issue_rob_o = '0;
    issue_s1_o  = '0;
    issue_s2_o  = '0;
    for (int k = 0; k < 4; k++) begin
      issue_op_o  = issue_op_o  | (op_r[k]     & {op_width_p{sel_g_s[k]}});
      issue_rob_o = issue_rob_o | (rob_r[k]    & {rob_width_p{sel_g_s[k]}});
      issue_s1_o  = issue_s1_o  | (s1_val_r[k] & {data_width_p{sel_g_s[k]}});
      issue_s2_o  = issue_s2_o  | (s2_val_r[k] & {data_width_p{sel_g_s[k]}});
    end
    count_o = count_r;
  end

  // Dispatching sources may be satisfied by the same-cycle CDB broadcast.
  always_comb begin
    d_s1_rdy_s = disp_s1_rdy_i | (cdb_v_i & (disp_s1_tag_i == cdb_tag_i));
    d_s2_rdy_s = disp_s2_rdy_i | (cdb_v_i & (disp_s2_tag_i == cdb_tag_i));
    if (disp_s1_rdy_i) d_s1_val_s = disp_s1_val_i;
    else               d_s1_val_s = cdb_val_i;
    if (disp_s2_rdy_i) d_s2_val_s = disp_s2_val_i;
    else               d_s2_val_s = cdb_val_i;
  end

  // Entry state: issue clear, CDB wakeup, dispatch write and occupancy count.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_r      <= 4'b0000;
      s1_rdy_r <= 4'b0000;
      s2_rdy_r <= 4'b0000;
      count_r  <= 3'd0;
      for (int k = 0; k < 4; k++) begin
        op_r[k]     <= '0;
        rob_r[k]    <= '0;
        s1_tag_r[k] <= '0;
        s2_tag_r[k] <= '0;
        s1_val_r[k] <= '0;
        s2_val_r[k] <= '0;
      end
    end else if (flush_i) begin
      v_r     <= 4'b0000;
      count_r <= 3'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (issue_yumi_i && sel_g_s[k]) v_r[k] <= 1'b0;
        if (cdb_v_i && v_r[k] && !s1_rdy_r[k] && (s1_tag_r[k] == cdb_tag_i)) begin
          s1_rdy_r[k] <= 1'b1;
          s1_val_r[k] <= cdb_val_i;
        end
        if (cdb_v_i && v_r[k] && !s2_rdy_r[k] && (s2_tag_r[k] == cdb_tag_i)) begin
          s2_rdy_r[k] <= 1'b1;
          s2_val_r[k] <= cdb_val_i;
        end
        // Free slots are never selected, so a dispatch write cannot collide with an issue clear.
        if (disp_fire_s && free_oh_s[k]) begin
          v_r[k]      <= 1'b1;
          op_r[k]     <= disp_op_i;
          rob_r[k]    <= disp_rob_i;
          s1_rdy_r[k] <= d_s1_rdy_s;
          s1_tag_r[k] <= disp_s1_tag_i;
          s1_val_r[k] <= d_s1_val_s;
          s2_rdy_r[k] <= d_s2_rdy_s;
          s2_tag_r[k] <= disp_s2_tag_i;
          s2_val_r[k] <= d_s2_val_s;
        end
      end
      count_r <= count_r + {2'b00, disp_fire_s} - {2'b00, yumi_fire_s};
    end
  end

endmodule
